alarma_dosis: RTL

Dose scheduler that consumes the 24-bit BCD time bus produced by the chronometer. It holds up to N_SLOTS programmed daily dose times and fires a dispense request when the bus reaches a programmed HH:MM. It then handshakes with the dispenser mechanism and waits for the patient's confirmation or a timeout. It sits between the chronometer and the dispenser motor/buzzer logic.

---
 rtl/alarma_dosis_pkg.sv | 31 +++
 rtl/dose_slot_bank.sv | 40 ++++
 rtl/alarma_dosis.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/alarma_dosis_pkg.sv
// Shared types and helpers for the dose scheduler: FSM states, BCD field
// offsets of the time bus and the HH:MM validity check.
`timescale 1ns/1ps
package alarma_dosis_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPENSE = 2'd1,
    ESPERA   = 2'd2
  } estado_e;

  localparam int unsigned HHMM_W    = 16;
  localparam int unsigned OFS_MIN1  = 0;
  localparam int unsigned OFS_MIN2  = 4;
  localparam int unsigned OFS_HORA1 = 8;
  localparam int unsigned OFS_HORA2 = 12;
  localparam int unsigned OFS_DIA1  = 16;
  localparam int unsigned OFS_DIA2  = 20;

  // A programmed time is matchable only if it is a real 00:00..23:59 BCD time.
  function automatic logic hhmm_valido(input logic [HHMM_W-1:0] hhmm);
    logic [3:0] h2, h1, m2, m1;
    h2 = hhmm[OFS_HORA2 +: 4];
    h1 = hhmm[OFS_HORA1 +: 4];
    m2 = hhmm[OFS_MIN2 +: 4];
    m1 = hhmm[OFS_MIN1 +: 4];
    return (h1 <= 4'd9) && (m2 <= 4'd5) && (m1 <= 4'd9) &&
           ((h2 < 4'd2) || ((h2 == 4'd2) && (h1 <= 4'd3)));
  endfunction

endpackage

// File: rtl/dose_slot_bank.sv
// Programmable dose slots: stored HH:MM, enable bit and a per-slot match
// against the current HH:MM field of the time bus.
`timescale 1ns/1ps
module dose_slot_bank
  import alarma_dosis_pkg::*;
#(
  parameter int unsigned N_SLOTS = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prog_we_i,
  input  logic [IDX_W-1:0]  prog_idx_i,
  input  logic [HHMM_W-1:0] prog_hhmm_i,
  input  logic              prog_en_i,
  input  logic [HHMM_W-1:0] hhmm_i,
  output logic [N_SLOTS-1:0] match_o
);

  logic [HHMM_W-1:0]  slot_q [N_SLOTS];
  logic [N_SLOTS-1:0] en_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q <= '0;
      for (int unsigned i = 0; i < N_SLOTS; i++) slot_q[i] <= '0;
    end else if (prog_we_i && (32'(prog_idx_i) < N_SLOTS)) begin
      slot_q[prog_idx_i] <= prog_hhmm_i;
      en_q[prog_idx_i]   <= prog_en_i;
    end
  end

  always_comb begin
    match_o = '0;
    for (int unsigned i = 0; i < N_SLOTS; i++) begin
      match_o[i] = en_q[i] && hhmm_valido(slot_q[i]) && (slot_q[i] == hhmm_i);
    end
  end

endmodule

// File: rtl/alarma_dosis.sv
// Dose scheduler top: tick detection on the BCD time bus, pending doses,
// lowest-index pick and the dispense/confirm FSM with its counters.
`timescale 1ns/1ps
module alarma_dosis
  import alarma_dosis_pkg::*;
#(
  parameter int unsigned N_SLOTS     = 4,
  parameter int unsigned TIMEOUT_MIN = 15,
  parameter int unsigned ACK_CICLOS  = 20000,
  localparam int unsigned IDX_W      = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [23:0]       tiempo,
  input  logic              prog_we,
  input  logic [IDX_W-1:0]  prog_idx,
  input  logic [HHMM_W-1:0] prog_hhmm,
  input  logic              prog_en,
  input  logic              disp_ack,
  input  logic              boton_tomar,
  output logic              disp_req,
  output logic [IDX_W-1:0]  disp_slot,
  output logic              alarma,
  output logic              dosis_tomada,
  output logic              dosis_perdida,
  output logic [7:0]        cuenta_perdidas,
  output logic              fallo_disp,
  output logic              pendiente
);

  localparam int unsigned ACK_W = $clog2(ACK_CICLOS + 1);

  estado_e            estado_q;
  logic [23:0]        tiempo_q;
  logic               primed_q;
  logic [N_SLOTS-1:0] pending_q, pending_d;
  logic [N_SLOTS-1:0] match;
  logic [ACK_W-1:0]   ack_cnt_q;
  logic [7:0]         min_cnt_q;
  logic               disp_req_q, alarma_q, tomada_q, perdida_q, fallo_q;
  logic [IDX_W-1:0]   disp_slot_q;
  logic [7:0]         cuenta_q;
  logic               tick;
  logic               pick_vld;
  logic [IDX_W-1:0]   pick_idx;

  dose_slot_bank #(
    .N_SLOTS (N_SLOTS),
    .IDX_W   (IDX_W)
  ) u_bank (
    .clk         (clk),
    .rst_n       (rst_n),
    .prog_we_i   (prog_we),
    .prog_idx_i  (prog_idx),
    .prog_hhmm_i (prog_hhmm),
    .prog_en_i   (prog_en),
    .hhmm_i      (tiempo[HHMM_W-1:0]),
    .match_o     (match)
  );

  assign tick = primed_q && (tiempo != tiempo_q);

  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int unsigned i = 0; i < N_SLOTS; i++) begin
      if (!pick_vld && pending_q[i]) begin
        pick_vld = 1'b1;
        pick_idx = IDX_W'(i);
      end
    end
  end

  // Order matters: pick clears, a new match sets, a slot write clears last.
  always_comb begin
    pending_d = pending_q;
    if ((estado_q == IDLE) && pick_vld) pending_d[pick_idx] = 1'b0;
    if (tick) pending_d = pending_d | match;
    if (prog_we && (32'(prog_idx) < N_SLOTS)) pending_d[prog_idx] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q    <= IDLE;
      tiempo_q    <= '0;
      primed_q    <= 1'b0;
      pending_q   <= '0;
      ack_cnt_q   <= '0;
      min_cnt_q   <= '0;
      disp_req_q  <= 1'b0;
      disp_slot_q <= '0;
      alarma_q    <= 1'b0;
      tomada_q    <= 1'b0;
      perdida_q   <= 1'b0;
      cuenta_q    <= '0;
      fallo_q     <= 1'b0;
    end else begin
      tiempo_q  <= tiempo;
      primed_q  <= 1'b1;
      pending_q <= pending_d;
      tomada_q  <= 1'b0;
      perdida_q <= 1'b0;
      case (estado_q)
        IDLE: begin
          if (pick_vld) begin
            estado_q    <= DISPENSE;
            disp_req_q  <= 1'b1;
            disp_slot_q <= pick_idx;
            ack_cnt_q   <= '0;
          end
        end
        DISPENSE: begin
          if (disp_ack) begin
            estado_q   <= ESPERA;
            disp_req_q <= 1'b0;
            alarma_q   <= 1'b1;
            min_cnt_q  <= '0;
          end else if (ack_cnt_q == ACK_W'(ACK_CICLOS - 1)) begin
            estado_q   <= IDLE;
            disp_req_q <= 1'b0;
            fallo_q    <= 1'b1;
          end else begin
            ack_cnt_q <= ack_cnt_q + 1'b1;
          end
        end
        ESPERA: begin
          if (boton_tomar) begin
            estado_q <= IDLE;
            alarma_q <= 1'b0;
            tomada_q <= 1'b1;
          end else if (tick) begin
            if (min_cnt_q == 8'(TIMEOUT_MIN - 1)) begin
              estado_q  <= IDLE;
              alarma_q  <= 1'b0;
              perdida_q <= 1'b1;
              if (cuenta_q != 8'hFF) cuenta_q <= cuenta_q + 8'd1;
            end else begin
              min_cnt_q <= min_cnt_q + 8'd1;
            end
          end
        end
        default: estado_q <= IDLE;
      endcase
    end
  end

  assign disp_req        = disp_req_q;
  assign disp_slot       = disp_slot_q;
  assign alarma          = alarma_q;
  assign dosis_tomada    = tomada_q;
  assign dosis_perdida   = perdida_q;
  assign cuenta_perdidas = cuenta_q;
  assign fallo_disp      = fallo_q;
  assign pendiente       = |pending_q;

endmodule
